// File: rtl/up3_seq.sv
// up3_seq: fetch/execute sequencer for the 8-bit teaching processor.
// Every instruction is two bytes (opcode, operand) and takes three run-cycles:
// S_F1 fetches the opcode, S_F2 fetches the operand, S_EX executes it.
// Memory reads are combinational; the address mux downstream picks pc while
// FETCH=1 and addr_value (the operand register) while FETCH=0.
module up3_seq #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] mem_rdata,
  output logic [7:0] pc,
  output logic [7:0] addr_value,
  output logic       FETCH,
  output logic       mem_we,
  output logic [7:0] mem_wdata,
  output logic [7:0] acc,
  output logic       carry,
  output logic       halted
);

  typedef enum logic [1:0] {
    S_F1   = 2'd0,
    S_F2   = 2'd1,
    S_EX   = 2'd2,
    S_HALT = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_LDI = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JZ  = 4'h6;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t     state;
  logic [7:0] pc_q;
  // Only the opcode nibble of the instruction byte is ever decoded, so the
  // low nibble is not stored at all.
  logic [3:0] ir_op;
  logic [7:0] opr_q;
  logic [7:0] acc_q;
  logic       carry_q;
  logic [8:0] add_sum;

  // 9-bit sum for ADD: bit 8 becomes the carry, ACC wraps mod 256.
  assign add_sum = {1'b0, acc_q} + {1'b0, mem_rdata};

  // Sequencer state and datapath registers; everything holds while run=0.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register in this block sees
    // the pre-edge values of the others (e.g. ADD reads the old ACC).
    if (reset) begin
      state   <= S_F1;
      pc_q    <= RESET_PC;
      ir_op   <= OP_NOP;
      opr_q   <= 8'h00;
      acc_q   <= 8'h00;
      carry_q <= 1'b0;
    end else if (run) begin
      case (state)
        S_F1: begin
          ir_op <= mem_rdata[7:4];
          pc_q  <= pc_q + 8'd1;
          state <= S_F2;
        end
        S_F2: begin
          opr_q <= mem_rdata;
          pc_q  <= pc_q + 8'd1;
          state <= S_EX;
        end
        S_EX: begin
          state <= S_F1;
          case (ir_op)
            OP_LDA: acc_q <= mem_rdata;
            OP_ADD: {carry_q, acc_q} <= add_sum;
            OP_LDI: acc_q <= opr_q;
            OP_JMP: pc_q <= opr_q;
            OP_JZ: begin
              if (acc_q == 8'h00) pc_q <= opr_q;
            end
            OP_HLT: state <= S_HALT;
            // STA has no register effect; its strobe is decoded below.
            OP_STA, OP_NOP: ;
            default: ;
          endcase
        end
        S_HALT: state <= S_HALT;
        default: state <= S_F1;
      endcase
    end
  end

  // Moore decode of the mux select and halt flag from state alone.
  always_comb begin
    FETCH  = (state == S_F1) || (state == S_F2);
    halted = (state == S_HALT);
  end

  // Write strobe: only in S_EX of a STA, only on a real step, never while
  // reset is abandoning the instruction.
  always_comb begin
    // NOTE: a single unconditional assignment keeps this purely
    // combinational; no path leaves mem_we unassigned, so no latch.
    mem_we = run && !reset && (state == S_EX) && (ir_op == OP_STA);
  end

  assign pc         = pc_q;
  assign addr_value = opr_q;
  assign mem_wdata  = acc_q;
  assign acc        = acc_q;
  assign carry      = carry_q;

endmodule

// File: tb/tb_up3_seq.sv
// Directed testbench for up3_seq: a 256-byte memory with combinational read
// sits behind a model of the address mux; each task loads a small program,
// steps the sequencer and compares against hand-computed values.
module tb_up3_seq;

  logic       clk;
  logic       reset;
  logic       run;
  logic [7:0] mem_rdata;
  logic [7:0] pc;
  logic [7:0] addr_value;
  logic       FETCH;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] acc;
  logic       carry;
  logic       halted;

  logic [7:0] mem [256];
  int n_tests;
  int n_fail;

  up3_seq #(.RESET_PC(8'h00)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .mem_rdata  (mem_rdata),
    .pc         (pc),
    .addr_value (addr_value),
    .FETCH      (FETCH),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .acc        (acc),
    .carry      (carry),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Address mux plus asynchronous-read memory.
  assign mem_rdata = mem[FETCH ? pc : addr_value];

  // One clock: capture the write strobe just before the edge, apply the
  // write at the edge, then settle 1 time unit past it.
  task automatic step();
    logic       we;
    logic [7:0] wa;
    logic [7:0] wd;
    we = mem_we;
    wa = addr_value;
    wd = mem_wdata;
    @(posedge clk);
    if (we) mem[wa] = wd;
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  // Reset with run low to show reset overrides run; leaves run=1.
  task automatic do_reset();
    reset = 1'b1;
    run   = 1'b0;
    step();
    reset = 1'b0;
    run   = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clear_mem();
    do_reset();
    n_tests++;
    if (pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc got=%h exp=00", pc); end
    n_tests++;
    if (FETCH !== 1'b1) begin n_fail++; $display("FAIL reset_fetch got=%b exp=1", FETCH); end
    n_tests++;
    if (mem_we !== 1'b0 || halted !== 1'b0) begin
      n_fail++; $display("FAIL reset_we_halt got=%b%b exp=00", mem_we, halted);
    end
    n_tests++;
    if (addr_value !== 8'h00 || acc !== 8'h00 || carry !== 1'b0) begin
      n_fail++; $display("FAIL reset_regs got=%h/%h/%b exp=00/00/0", addr_value, acc, carry);
    end
  endtask

  // LDI 05; ADD [10] with mem[10]=07.
  task automatic test_ldi_add();
    logic exp_fetch [6];
    exp_fetch = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    clear_mem();
    mem[0] = 8'h40; mem[1] = 8'h05; mem[2] = 8'h30; mem[3] = 8'h10;
    mem[8'h10] = 8'h07;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (FETCH !== exp_fetch[i]) begin
        n_fail++; $display("FAIL fetch_seq[%0d] got=%b exp=%b", i, FETCH, exp_fetch[i]);
      end
      step();
    end
    n_tests++;
    if (acc !== 8'h0C || carry !== 1'b0 || pc !== 8'h04) begin
      n_fail++; $display("FAIL ldi_add got acc=%h c=%b pc=%h exp acc=0c c=0 pc=04", acc, carry, pc);
    end
  endtask

  // LDI FF; ADD [20] with mem[20]=02 -> wraps with carry.
  task automatic test_carry();
    clear_mem();
    mem[0] = 8'h40; mem[1] = 8'hFF; mem[2] = 8'h30; mem[3] = 8'h20;
    mem[8'h20] = 8'h02;
    do_reset();
    steps(6);
    n_tests++;
    if (acc !== 8'h01 || carry !== 1'b1) begin
      n_fail++; $display("FAIL add_carry got acc=%h c=%b exp acc=01 c=1", acc, carry);
    end
  endtask

  task automatic test_jz();
    // Taken: LDI 00; JZ 30.
    clear_mem();
    mem[0] = 8'h40; mem[1] = 8'h00; mem[2] = 8'h60; mem[3] = 8'h30;
    do_reset();
    steps(6);
    n_tests++;
    if (pc !== 8'h30) begin n_fail++; $display("FAIL jz_taken got pc=%h exp=30", pc); end
    // Not taken: NOP; LDI 01; JZ 30.
    clear_mem();
    mem[2] = 8'h40; mem[3] = 8'h01; mem[4] = 8'h60; mem[5] = 8'h30;
    do_reset();
    steps(9);
    n_tests++;
    if (pc !== 8'h06 || acc !== 8'h01) begin
      n_fail++; $display("FAIL jz_not_taken got pc=%h acc=%h exp pc=06 acc=01", pc, acc);
    end
  endtask

  // LDI A5; STA 40 -> exactly one write strobe, in the STA execute cycle.
  task automatic test_sta();
    int we_count;
    we_count = 0;
    clear_mem();
    mem[0] = 8'h40; mem[1] = 8'hA5; mem[2] = 8'h20; mem[3] = 8'h40;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (mem_we === 1'b1) we_count++;
      if (i == 5) begin
        n_tests++;
        if (mem_we !== 1'b1 || addr_value !== 8'h40 || mem_wdata !== 8'hA5 || FETCH !== 1'b0) begin
          n_fail++;
          $display("FAIL sta_strobe got we=%b addr=%h wd=%h fetch=%b exp we=1 addr=40 wd=a5 fetch=0",
                   mem_we, addr_value, mem_wdata, FETCH);
        end
      end
      step();
    end
    n_tests++;
    if (we_count != 1) begin n_fail++; $display("FAIL sta_pulse_count got=%0d exp=1", we_count); end
    n_tests++;
    if (mem[8'h40] !== 8'hA5) begin n_fail++; $display("FAIL sta_mem got=%h exp=a5", mem[8'h40]); end
  endtask

  // Four NOPs then HLT at 08.
  task automatic test_halt();
    logic ok;
    clear_mem();
    mem[8] = 8'hF0;
    do_reset();
    steps(15);
    n_tests++;
    if (halted !== 1'b1 || FETCH !== 1'b0 || pc !== 8'h0A || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL halt_entry got h=%b f=%b pc=%h we=%b exp h=1 f=0 pc=0a we=0",
                         halted, FETCH, pc, mem_we);
    end
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (halted !== 1'b1 || pc !== 8'h0A || FETCH !== 1'b0) ok = 1'b0;
    end
    n_tests++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL halt_hold got h=%b pc=%h exp h=1 pc=0a", halted, pc); end
    do_reset();
    n_tests++;
    if (pc !== 8'h00 || halted !== 1'b0 || FETCH !== 1'b1) begin
      n_fail++; $display("FAIL halt_reset got pc=%h h=%b f=%b exp pc=00 h=0 f=1", pc, halted, FETCH);
    end
  endtask

  // Freeze in S_F2, then reset during S_EX of a STA.
  task automatic test_run_and_reset();
    logic ok;
    clear_mem();
    mem[0] = 8'h40; mem[1] = 8'hA5; mem[2] = 8'h20; mem[3] = 8'h40;
    do_reset();
    step();                      // now in S_F2, pc=01
    run = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (pc !== 8'h01 || FETCH !== 1'b1 || mem_we !== 1'b0 || acc !== 8'h00 || addr_value !== 8'h00)
        ok = 1'b0;
    end
    n_tests++;
    if (ok !== 1'b1) begin
      n_fail++; $display("FAIL run_freeze got pc=%h f=%b we=%b acc=%h exp pc=01 f=1 we=0 acc=00",
                         pc, FETCH, mem_we, acc);
    end
    run = 1'b1;
    steps(4);                    // S_F2 -> S_EX(LDI) -> S_F1 -> S_F2 -> S_EX(STA)
    n_tests++;
    if (mem_we !== 1'b1 || pc !== 8'h04 || acc !== 8'hA5) begin
      n_fail++; $display("FAIL sta_ready got we=%b pc=%h acc=%h exp we=1 pc=04 acc=a5", mem_we, pc, acc);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_blocks_we got=%b exp=0", mem_we); end
    step();
    reset = 1'b0;
    #1;
    n_tests++;
    if (mem[8'h40] !== 8'h00) begin n_fail++; $display("FAIL reset_no_write got=%h exp=00", mem[8'h40]); end
    n_tests++;
    if (pc !== 8'h00 || FETCH !== 1'b1 || acc !== 8'h00 || addr_value !== 8'h00) begin
      n_fail++; $display("FAIL post_reset got pc=%h f=%b acc=%h addr=%h exp pc=00 f=1 acc=00 addr=00",
                         pc, FETCH, acc, addr_value);
    end
  endtask

  // JMP FE; LDI 77 at FE/FF -> pc wraps to 00.
  task automatic test_pc_wrap();
    clear_mem();
    mem[0] = 8'h50; mem[1] = 8'hFE;
    mem[8'hFE] = 8'h40; mem[8'hFF] = 8'h77;
    do_reset();
    steps(3);
    n_tests++;
    if (pc !== 8'hFE) begin n_fail++; $display("FAIL jmp got pc=%h exp=fe", pc); end
    steps(2);
    n_tests++;
    if (pc !== 8'h00 || addr_value !== 8'h77) begin
      n_fail++; $display("FAIL pc_wrap got pc=%h opr=%h exp pc=00 opr=77", pc, addr_value);
    end
    step();
    n_tests++;
    if (acc !== 8'h77 || pc !== 8'h00 || FETCH !== 1'b1) begin
      n_fail++; $display("FAIL wrap_exec got acc=%h pc=%h f=%b exp acc=77 pc=00 f=1", acc, pc, FETCH);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    run     = 1'b0;
    clear_mem();
    test_reset();
    test_ldi_add();
    test_carry();
    test_jz();
    test_sta();
    test_halt();
    test_run_and_reset();
    test_pc_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
